ctrl_sequencer: RTL and testbench
=================================

Name: ctrl_sequencer

Overview:
- Parametrised successor to the single-cycle control unit.
- Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer for the VR16 core.
- Owns the architectural flag register, the retired-instruction counter, halt handling and the execute-timeout fault.
- Sits between the instruction memory interface, the decoder and the ALU, and drives their phase enables.

Parameters:
- FLAG_W, 4, width of the flag register (Z, C, N, V in bits 0..3 by default).
- CNT_W, 16, width of the retired-instruction counter.
- TMO_W, 8, width of the execute-timeout counter.
- EXEC_TIMEOUT, 200, EXECUTE cycles without alu_done before FAULT; must be at least 1 and below 2^TMO_W.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- start  in  1  level; leaves IDLE or HALTED.
- halt_req  in  1  level; request to stop at the next instruction boundary.
- mem_ready  in  1  instruction memory has data for fetch_req.
- alu_done  in  1  execute phase complete.
- flags_we  in  1  qualifies flags_in; sampled only with alu_done.
- flags_in  in  FLAG_W  new flag value from the ALU.
- fetch_req  out  1  high throughout FETCH.
- decode_en  out  1  high in DECODE.
- exec_en  out  1  high throughout EXECUTE.
- wb_en  out  1  high in WRITEBACK.
- ins_retired  out  1  one-cycle pulse, equal to wb_en.
- flags_out  out  FLAG_W  registered flag register.
- ins_count  out  CNT_W  instructions retired.
- busy  out  1  state is FETCH, DECODE, EXECUTE or WRITEBACK.
- halted  out  1  state is HALTED.
- fault  out  1  state is FAULT.

Behaviour:
- All state updates on the clk rising edge. reset low at an edge puts the block in IDLE from any state, including mid-instruction.
- Reset values: flags_out=0, ins_count=0, halt_pending=0, timeout counter=0, all 1-bit outputs 0.
- Outputs are Moore, decoded from the state register. No combinational path from inputs to outputs.
- States are IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALTED, FAULT.
- IDLE: start=1 -> FETCH; otherwise stay.
- FETCH: fetch_req=1. mem_ready=1 -> DECODE; otherwise stay, with no limit on wait time.
- DECODE: exactly one cycle, then -> EXECUTE. The timeout counter is cleared on entry to EXECUTE.
- EXECUTE, alu_done=1: go to WRITEBACK. If flags_we=1 in the same cycle, flags_out <= flags_in.
- EXECUTE, alu_done=0: the timeout counter increments. When the counter equals EXEC_TIMEOUT-1 -> FAULT.
- EXECUTE timeout boundary: alu_done=1 in the same cycle as the timeout condition means alu_done wins; no fault is raised.
- WRITEBACK: one cycle. ins_count <= ins_count+1, wrapping from 2^CNT_W-1 to 0. Next state is HALTED if (halt_pending | halt_req), otherwise FETCH.
- halt_pending is set when halt_req=1 in FETCH, DECODE or EXECUTE. It is cleared on entry to HALTED. A halt_req pulse therefore never aborts an in-flight instruction.
- HALTED: start=1 and halt_req=0 -> FETCH. If start=1 and halt_req=1, stay HALTED.
- FAULT: sticky; only reset leaves it. flags_out and ins_count are frozen.
- flags_out changes only in EXECUTE on the alu_done & flags_we edge.

Optional Feature:
- Macro: CTRL_SEQ_PERF_EN.
- Defined: adds output stall_count[CNT_W-1:0]. Reset 0. Increments every cycle in FETCH with mem_ready=0 or in EXECUTE with alu_done=0, and saturates at all-ones.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Shared package/include ctrl_pkg holds:
  - state encoding localparams (3-bit: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, WRITEBACK=4, HALTED=5, FAULT=6);
  - flag bit index constants;
  - default widths.
- One sub-module, wrap_counter (width parameter, synchronous active-low clear, enable, wrap-around). It is instantiated for ins_count. The timeout counter uses it via clear-on-DECODE.

Test Plan:
- Reset then start=1; mem_ready on the 3rd FETCH cycle; alu_done on the 2nd EXECUTE cycle with flags_we=1, flags_in=4'b1010 -> after WRITEBACK: ins_count=1, flags_out=4'b1010, ins_retired high exactly 1 cycle.
- alu_done=1 with flags_we=0 and flags_in=4'hF -> flags_out unchanged; ins_count still increments.
- halt_req pulsed 1 cycle during EXECUTE -> instruction completes, ins_count +1, then HALTED with halted=1. start=1 -> FETCH.
- EXEC_TIMEOUT=4, alu_done held 0 -> fault=1 after 4 EXECUTE cycles and persists. alu_done asserted on the 4th cycle instead -> WRITEBACK, no fault.
- CNT_W=4: retire 17 instructions -> ins_count wraps 15 -> 0 and ends at 1.
- reset driven low in EXECUTE -> next cycle IDLE with all outputs 0. reset held low with start=1 -> stays IDLE.

Source files
------------

// File: rtl/ctrl_sequencer_pkg.sv
// ctrl_pkg: shared state encoding, flag bit positions and default widths for
// the VR16 control sequencer.
package ctrl_pkg;

    // Default widths and timeout
    localparam int FLAG_W_DEF       = 4;
    localparam int CNT_W_DEF        = 16;
    localparam int TMO_W_DEF        = 8;
    localparam int EXEC_TIMEOUT_DEF = 200;

    // Flag bit positions within flags_out
    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;

    // Sequencer state encoding (3-bit)
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALTED    = 3'd5,
        ST_FAULT     = 3'd6
    } state_t;

    // True while an instruction is in flight
    function automatic logic is_busy(state_t s);
        return (s == ST_FETCH) || (s == ST_DECODE) ||
               (s == ST_EXECUTE) || (s == ST_WRITEBACK);
    endfunction

endpackage

// File: rtl/ctrl_sequencer_if.sv
// ctrl_sequencer_if: handshake/phase bundle between the sequencer (slave)
// and the surrounding core (master). stall_count exists only when
// CTRL_SEQ_PERF_EN is defined.
interface ctrl_sequencer_if #(
    parameter int FLAG_W = 4,
    parameter int CNT_W  = 16
);
    logic              start;
    logic              halt_req;
    logic              mem_ready;
    logic              alu_done;
    logic              flags_we;
    logic [FLAG_W-1:0] flags_in;

    logic              fetch_req;
    logic              decode_en;
    logic              exec_en;
    logic              wb_en;
    logic              ins_retired;
    logic [FLAG_W-1:0] flags_out;
    logic [CNT_W-1:0]  ins_count;
    logic              busy;
    logic              halted;
    logic              fault;
`ifdef CTRL_SEQ_PERF_EN
    logic [CNT_W-1:0]  stall_count;
`endif

    modport master (
        output start, halt_req, mem_ready, alu_done, flags_we, flags_in,
        input  fetch_req, decode_en, exec_en, wb_en, ins_retired,
        input  flags_out, ins_count, busy, halted, fault
`ifdef CTRL_SEQ_PERF_EN
        , input stall_count
`endif
    );

    modport slave (
        input  start, halt_req, mem_ready, alu_done, flags_we, flags_in,
        output fetch_req, decode_en, exec_en, wb_en, ins_retired,
        output flags_out, ins_count, busy, halted, fault
`ifdef CTRL_SEQ_PERF_EN
        , output stall_count
`endif
    );

endinterface

// File: rtl/ctrl_sequencer_wrap_counter.sv
// wrap_counter: free-running up counter with synchronous active-low clear
// and enable; wraps from all-ones to zero.
module wrap_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         en,
    output logic [W-1:0] count
);

    // Clear dominates enable; natural overflow gives the wrap
    always_ff @(posedge clk) begin
        if (!clr_n)
            count <= '0;
        else if (en)
            count <= count + W'(1);
    end

endmodule

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer for
// the VR16 core. Owns the flag register, retired-instruction counter, halt
// handling and execute-timeout fault. Optional macro CTRL_SEQ_PERF_EN adds
// a saturating stall counter.
module ctrl_sequencer
    import ctrl_pkg::*;
#(
    parameter int FLAG_W       = FLAG_W_DEF,
    parameter int CNT_W        = CNT_W_DEF,
    parameter int TMO_W        = TMO_W_DEF,
    parameter int EXEC_TIMEOUT = EXEC_TIMEOUT_DEF  // 1 .. 2^TMO_W-1
) (
    input  logic            clk,
    input  logic            reset,
    ctrl_sequencer_if.slave bus
);

    // Counter value seen on the last EXECUTE cycle before a fault
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(EXEC_TIMEOUT - 1);

    state_t            state;
    logic              halt_pending;
    logic [FLAG_W-1:0] flags_q;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [CNT_W-1:0]  ins_cnt;
    logic              tmo_clr_n;
    logic              tmo_en;
    logic              ret_en;

    // Timeout counter restarts in DECODE so every EXECUTE starts from zero
    assign tmo_clr_n = reset && (state != ST_DECODE);
    assign tmo_en    = (state == ST_EXECUTE) && !bus.alu_done;
    assign ret_en    = (state == ST_WRITEBACK);

    wrap_counter #(.W(TMO_W)) u_tmo_cnt (
        .clk   (clk),
        .clr_n (tmo_clr_n),
        .en    (tmo_en),
        .count (tmo_cnt)
    );

    // Retire counter; FAULT never reaches WRITEBACK so it stays frozen there
    wrap_counter #(.W(CNT_W)) u_ins_cnt (
        .clk   (clk),
        .clr_n (reset),
        .en    (ret_en),
        .count (ins_cnt)
    );

    // Sequencer FSM with halt bookkeeping and flag register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= ST_IDLE;
            halt_pending <= 1'b0;
            flags_q      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start)
                        state <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (bus.halt_req)
                        halt_pending <= 1'b1;
                    if (bus.mem_ready)
                        state <= ST_DECODE;
                end
                ST_DECODE: begin
                    if (bus.halt_req)
                        halt_pending <= 1'b1;
                    state <= ST_EXECUTE;
                end
                ST_EXECUTE: begin
                    if (bus.halt_req)
                        halt_pending <= 1'b1;
                    // alu_done beats the timeout when both land together
                    if (bus.alu_done) begin
                        state <= ST_WRITEBACK;
                        if (bus.flags_we)
                            flags_q <= bus.flags_in;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state <= ST_FAULT;
                    end
                end
                ST_WRITEBACK: begin
                    if (halt_pending || bus.halt_req) begin
                        state        <= ST_HALTED;
                        halt_pending <= 1'b0;
                    end else begin
                        state <= ST_FETCH;
                    end
                end
                ST_HALTED: begin
                    if (bus.start && !bus.halt_req)
                        state <= ST_FETCH;
                end
                ST_FAULT: begin
                    state <= ST_FAULT;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Moore outputs decoded straight from the state register
    assign bus.fetch_req   = (state == ST_FETCH);
    assign bus.decode_en   = (state == ST_DECODE);
    assign bus.exec_en     = (state == ST_EXECUTE);
    assign bus.wb_en       = (state == ST_WRITEBACK);
    assign bus.ins_retired = (state == ST_WRITEBACK);
    assign bus.busy        = is_busy(state);
    assign bus.halted      = (state == ST_HALTED);
    assign bus.fault       = (state == ST_FAULT);
    assign bus.flags_out   = flags_q;
    assign bus.ins_count   = ins_cnt;

`ifdef CTRL_SEQ_PERF_EN
    logic [CNT_W-1:0] stall_q;
    logic             stall_cyc;

    assign stall_cyc = ((state == ST_FETCH) && !bus.mem_ready) ||
                       ((state == ST_EXECUTE) && !bus.alu_done);

    // Saturating count of cycles spent waiting on memory or the ALU
    always_ff @(posedge clk) begin
        if (!reset)
            stall_q <= '0;
        else if (stall_cyc && (stall_q != '1))
            stall_q <= stall_q + CNT_W'(1);
    end

    assign bus.stall_count = stall_q;
`endif

endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb_ctrl_sequencer: directed plus randomized instruction-level checks of
// ctrl_sequencer with CNT_W=4 and EXEC_TIMEOUT=4.
module tb_ctrl_sequencer;

    localparam int FW  = 4;
    localparam int CW  = 4;
    localparam int TMO = 4;
    localparam int CNT_MOD = 1 << CW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    ctrl_sequencer_if #(.FLAG_W(FW), .CNT_W(CW)) bus ();

    ctrl_sequencer #(
        .FLAG_W       (FW),
        .CNT_W        (CW),
        .TMO_W        (8),
        .EXEC_TIMEOUT (TMO)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus.slave)
    );

    int          n_chk = 0;
    int          n_err = 0;
    int          exp_cnt = 0;
    logic [3:0]  exp_flags = 4'h0;
    int          exp_stall = 0;
    byte         last_c = "I";

    logic [7:0] obs_outs;
    assign obs_outs = {bus.fetch_req, bus.decode_en, bus.exec_en, bus.wb_en,
                       bus.ins_retired, bus.busy, bus.halted, bus.fault};

    // Expected {fetch,decode,exec,wb,retired,busy,halted,fault} per phase
    function automatic logic [7:0] ph(byte c);
        case (c)
            "F":     return 8'b1000_0100;
            "D":     return 8'b0100_0100;
            "E":     return 8'b0010_0100;
            "W":     return 8'b0001_1100;
            "H":     return 8'b0000_0010;
            "X":     return 8'b0000_0001;
            default: return 8'b0000_0000;
        endcase
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and check that the DUT is in phase c
    task automatic cyc(byte c, string tag);
        if (!rst_n)
            exp_stall = 0;
        else if (((last_c == "F") && !bus.mem_ready) ||
                 ((last_c == "E") && !bus.alu_done))
            if (exp_stall < CNT_MOD - 1) exp_stall++;
        @(negedge clk);
        chk({tag, "/outs"},  {24'd0, obs_outs}, {24'd0, ph(c)});
        chk({tag, "/count"}, 32'(bus.ins_count), 32'(exp_cnt));
        chk({tag, "/flags"}, 32'(bus.flags_out), 32'(exp_flags));
`ifdef CTRL_SEQ_PERF_EN
        chk({tag, "/stall"}, 32'(bus.stall_count), 32'(exp_stall));
`endif
        last_c = c;
    endtask

    // One full instruction starting from FETCH: fw wait cycles in FETCH,
    // alu_done on the el-th EXECUTE cycle, optional halt pulse in EXECUTE
    task automatic run_instr(int fw, int el, bit we, logic [3:0] fin, bit hp);
        for (int i = 0; i <= fw; i++) begin
            cyc("F", "fetch");
            bus.start     = 1'b0;
            bus.mem_ready = (i == fw);
        end
        cyc("D", "decode");
        bus.mem_ready = 1'b0;
        for (int j = 1; j <= el; j++) begin
            cyc("E", "exec");
            bus.alu_done = (j == el);
            bus.halt_req = hp && (j == 1);
            if (j == el) begin
                bus.flags_we = we;
                bus.flags_in = fin;
            end else begin
                bus.flags_we = 1'($urandom);
                bus.flags_in = 4'($urandom);
            end
        end
        if (we) exp_flags = fin;
        cyc("W", "wb");
        bus.alu_done = 1'b0;
        bus.flags_we = 1'b0;
        bus.halt_req = 1'b0;
        exp_cnt = (exp_cnt + 1) % CNT_MOD;
    endtask

    initial begin
        int         fw, el;
        bit         we, hp;
        logic [3:0] fin;

        bus.start     = 1'b0;
        bus.halt_req  = 1'b0;
        bus.mem_ready = 1'b0;
        bus.alu_done  = 1'b0;
        bus.flags_we  = 1'b0;
        bus.flags_in  = 4'h0;

        // Reset state
        cyc("I", "reset0");
        cyc("I", "reset1");
        rst_n = 1'b1;
        cyc("I", "idle");
        bus.start = 1'b1;

        // Basic instruction, then flags_we=0 leaves flags alone
        run_instr(2, 2, 1'b1, 4'b1010, 1'b0);
        run_instr(0, 1, 1'b0, 4'hF, 1'b0);

        // Halt pulse in EXECUTE finishes the instruction then halts
        fin = 4'($urandom);
        run_instr(1, 3, 1'b1, fin, 1'b1);
        cyc("H", "halted");
        cyc("H", "halted_hold");
        bus.start    = 1'b1;
        bus.halt_req = 1'b1;
        cyc("H", "halt_start_blocked");
        bus.halt_req = 1'b0;

        // alu_done on the last allowed EXECUTE cycle wins over timeout
        run_instr(0, TMO, 1'b1, 4'h5, 1'b0);

        // Randomized instruction stream; retire count wraps past 15
        for (int k = 0; k < 20; k++) begin
            fw  = int'($urandom_range(0, 3));
            el  = int'($urandom_range(1, TMO));
            we  = 1'($urandom);
            fin = 4'($urandom);
            hp  = ($urandom_range(0, 3) == 0);
            run_instr(fw, el, we, fin, hp);
            if (hp) begin
                cyc("H", "rand_halt");
                bus.start = 1'b1;
            end
        end

        // Execute timeout: fault is sticky, flags and count frozen
        cyc("F", "tmo_fetch");
        bus.start     = 1'b0;
        bus.mem_ready = 1'b1;
        cyc("D", "tmo_decode");
        bus.mem_ready = 1'b0;
        for (int j = 0; j < TMO; j++)
            cyc("E", "tmo_exec");
        cyc("X", "fault");
        bus.alu_done = 1'b1;
        bus.flags_we = 1'b1;
        bus.flags_in = ~exp_flags;
        bus.start    = 1'b1;
        repeat (3) cyc("X", "fault_sticky");

        // Reset clears FAULT
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.alu_done = 1'b0;
        bus.flags_we = 1'b0;
        exp_cnt      = 0;
        exp_flags    = 4'h0;
        cyc("I", "rst_from_fault");
        rst_n     = 1'b1;
        bus.start = 1'b1;

        // Reset in the middle of EXECUTE, held with start=1
        cyc("F", "mid_fetch");
        bus.start     = 1'b0;
        bus.mem_ready = 1'b1;
        cyc("D", "mid_decode");
        bus.mem_ready = 1'b0;
        bus.flags_we  = 1'b1;
        bus.flags_in  = 4'hC;
        cyc("E", "mid_exec");
        rst_n     = 1'b0;
        bus.start = 1'b1;
        cyc("I", "rst_mid_exec");
        cyc("I", "rst_hold_start");
        rst_n        = 1'b1;
        bus.start    = 1'b0;
        bus.flags_we = 1'b0;
        cyc("I", "idle_after_rst");
        bus.start = 1'b1;
        run_instr(0, 1, 1'b1, 4'h3, 1'b0);
        cyc("F", "final");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
